tmr_scrub_controller: RTL and testbench
=======================================

Name: tmr_scrub_controller

Overview:
- Background scrubber for a bank of NUM_REGS triplicated configuration registers, each N bits wide.
- Walks the bank one address at a time and reads all K copies through the external voter array.
- On a voter mismatch, issues a write-back of the voted value to all copies, arbitrating against user writes.
- Sits beside the register bank and its voter array; provides mismatch/correction statistics to slow control.

Parameters:
NUM_REGS, 16, number of triplicated registers scrubbed (>=2)
N, 16, register data width
PERIOD, 256, idle cycles between consecutive address scrubs (>=1)
CNT_W, 16, width of the statistics counters
ADDR_W, $clog2(NUM_REGS), derived address width, not to be overridden

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous active-low reset
enable_i  in  1  scrubbing enable (level)
clear_cnt_i  in  1  synchronous clear of statistics counters
rd_en_o  out  1  one-cycle read strobe to the register bank
rd_addr_o  out  ADDR_W  address being scrubbed
vote_data_i  in  N  voted value from the voter array, valid 1 cycle after rd_en_o
vote_mismatch_i  in  1  voter mismatch flag, valid with vote_data_i
user_wr_i  in  1  user write to the bank this cycle
user_addr_i  in  ADDR_W  user write address
wb_req_o  out  1  write-back request
wb_addr_o  out  ADDR_W  write-back address
wb_data_o  out  N  write-back data (voted value)
wb_gnt_i  in  1  write-back grant; the write happens in the cycle req&gnt
mismatch_cnt_o  out  CNT_W  saturating count of detected mismatches
corrected_cnt_o  out  CNT_W  saturating count of completed write-backs
round_done_o  out  1  one-cycle pulse after the last address is scrubbed
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; pointer, period counter, both statistics counters and wb_data_o cleared to 0. All strobes/pulses (rd_en_o, wb_req_o, round_done_o, busy_o) are 0.
- FSM states: IDLE, WAIT, READ, CAPTURE, WB, NEXT.
- IDLE: stays while enable_i=0. When enable_i=1, goes to WAIT and loads the period counter with PERIOD-1.
- WAIT: decrements the counter. At 0, goes to READ. A scrub therefore starts PERIOD cycles after WAIT entry.
- READ: rd_en_o=1 for exactly one cycle, rd_addr_o=pointer. Next state is CAPTURE.
- CAPTURE: samples vote_data_i into wb_data_o and samples vote_mismatch_i.
  - Mismatch=1: mismatch_cnt_o increments (saturating at all-ones). Next state is WB, or NEXT if a user write to the same address occurs this cycle.
  - Mismatch=0: next state is NEXT.
- WB: wb_req_o=1, wb_addr_o=pointer, and wb_data_o held stable until granted.
  - On wb_gnt_i=1: corrected_cnt_o increments (saturating), then NEXT.
  - If user_wr_i=1 with user_addr_i equal to the pointer in any WB cycle before the grant: the request is dropped (req deasserted next cycle) and no correction is counted. The user value supersedes the voted one.
  - If the grant and a same-address user write arrive in the same cycle, the grant wins. The write-back counts as completed. The bank's external arbiter orders the two writes.
- NEXT: the pointer increments and wraps from NUM_REGS-1 to 0. round_done_o pulses in the cycle of the wrap.
  - enable_i=1: go to WAIT and reload the counter.
  - enable_i=0: go to IDLE.
- enable_i dropping mid-scrub: the current address completes through NEXT; it is never aborted. The pointer is retained across IDLE; scrubbing resumes at the next address.
- Latency per clean address: PERIOD+3 cycles (WAIT..NEXT).
- clear_cnt_i: zeroes both counters next cycle and takes priority over a simultaneous increment.
- Mid-operation reset: returns everything to reset values next edge; wb_req_o drops immediately after that edge.
- user_wr_i has no effect outside CAPTURE/WB.

Optional Feature:
- Macro TMR_SCRUB_ERR_LOG_EN.
- Defined: adds outputs err_sticky_o (1 bit) and last_err_addr_o (ADDR_W).
  - On each CAPTURE with mismatch: last_err_addr_o is loaded with the pointer and err_sticky_o is set.
  - Both are cleared by reset or clear_cnt_i.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- NUM_REGS=4, PERIOD=2, enable held, no mismatch -> rd_en_o every 5 cycles at addresses 0,1,2,3,0; round_done_o pulses once per wrap; wb_req_o never asserts.
- Mismatch at addr 2 with vote_data_i=16'hA5A5, gnt 3 cycles after req -> wb_req_o high for 3 cycles with wb_addr_o=2, wb_data_o=A5A5; both counters read 1.
- Same as previous, but user_wr_i at addr 2 in the second WB cycle -> wb_req_o drops; mismatch_cnt_o=1, corrected_cnt_o=0.
- CNT_W=2, five mismatches -> mismatch_cnt_o saturates at 3; clear_cnt_i together with a sixth mismatch -> reads 0.
- enable_i deasserted during WB -> write-back completes, FSM goes to IDLE with pointer advanced; re-enable -> next read is at pointer+1.
- rst_n_i low during WB -> wb_req_o=0 after the edge, pointer and counters 0; with TMR_SCRUB_ERR_LOG_EN, err_sticky_o=0 and last_err_addr_o=0.

Source files
------------

// File: rtl/tmr_scrub_if.sv
// tmr_scrub_if: read, vote and write-back signals between the scrub controller
// and the triplicated register bank / voter array.
// The controller side uses the master modport, the bank side the slave modport.
interface tmr_scrub_if #(
   parameter int ADDR_W = 4,
   parameter int N      = 16
);
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [N-1:0]      vote_data_i;
   logic              vote_mismatch_i;
   logic              user_wr_i;
   logic [ADDR_W-1:0] user_addr_i;
   logic              wb_req_o;
   logic [ADDR_W-1:0] wb_addr_o;
   logic [N-1:0]      wb_data_o;
   logic              wb_gnt_i;

   modport master (
      output rd_en_o, rd_addr_o, wb_req_o, wb_addr_o, wb_data_o,
      input  vote_data_i, vote_mismatch_i, user_wr_i, user_addr_i, wb_gnt_i
   );

   modport slave (
      input  rd_en_o, rd_addr_o, wb_req_o, wb_addr_o, wb_data_o,
      output vote_data_i, vote_mismatch_i, user_wr_i, user_addr_i, wb_gnt_i
   );
endinterface

// File: rtl/tmr_scrub_controller.sv
// tmr_scrub_controller: background scrubber for a bank of triplicated registers.
// It walks the bank one address every PERIOD idle cycles and reads the voted value.
// On a voter mismatch it writes the voted value back to all copies, yielding to a
// same-address user write. It also keeps saturating mismatch/correction counters.
// Optional build macro TMR_SCRUB_ERR_LOG_EN adds err_sticky_o and last_err_addr_o.
module tmr_scrub_controller #(
   parameter  int NUM_REGS = 16,
   parameter  int N        = 16,
   parameter  int PERIOD   = 256,
   parameter  int CNT_W    = 16,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             enable_i,
   input  logic             clear_cnt_i,
   tmr_scrub_if.master      bus,
   output logic [CNT_W-1:0] mismatch_cnt_o,
   output logic [CNT_W-1:0] corrected_cnt_o,
   output logic             round_done_o,
   output logic             busy_o
`ifdef TMR_SCRUB_ERR_LOG_EN
   ,
   output logic              err_sticky_o,
   output logic [ADDR_W-1:0] last_err_addr_o
`endif
);

   // Period counter only has to hold PERIOD-1.
   localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_READ,
      S_CAPTURE,
      S_WB,
      S_NEXT
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [PER_W-1:0]  r_period_cnt;
   logic [CNT_W-1:0]  r_mis_cnt;
   logic [CNT_W-1:0]  r_cor_cnt;
   logic [N-1:0]      r_wb_data;

   logic              w_user_hit;
   logic              w_ptr_last;
   logic              w_load_period;
   logic              w_mis_inc;
   logic              w_cor_inc;

   // A user write to the address being scrubbed supersedes the voted value.
   assign w_user_hit    = bus.user_wr_i && (bus.user_addr_i == r_ptr);
   assign w_ptr_last    = (r_ptr == ADDR_W'(NUM_REGS - 1));
   assign w_load_period = enable_i && ((r_state == S_IDLE) || (r_state == S_NEXT));
   assign w_mis_inc     = (r_state == S_CAPTURE) && bus.vote_mismatch_i;
   // Grant wins over a same-cycle user write: the write-back still counts.
   assign w_cor_inc     = (r_state == S_WB) && bus.wb_gnt_i;

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state decode; an address in flight always runs through NEXT.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (enable_i) w_state_next = S_WAIT;
         S_WAIT:    if (r_period_cnt == '0) w_state_next = S_READ;
         S_READ:    w_state_next = S_CAPTURE;
         S_CAPTURE: w_state_next = (bus.vote_mismatch_i && !w_user_hit) ? S_WB : S_NEXT;
         S_WB:      if (bus.wb_gnt_i || w_user_hit) w_state_next = S_NEXT;
         S_NEXT:    w_state_next = enable_i ? S_WAIT : S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // Period countdown, address pointer and captured voted value.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_period_cnt <= '0;
         r_ptr        <= '0;
         r_wb_data    <= '0;
      end else begin
         if (w_load_period)
            r_period_cnt <= PER_W'(PERIOD - 1);
         else if ((r_state == S_WAIT) && (r_period_cnt != '0))
            r_period_cnt <= r_period_cnt - 1'b1;

         if (r_state == S_NEXT)
            r_ptr <= w_ptr_last ? '0 : r_ptr + 1'b1;

         if (r_state == S_CAPTURE)
            r_wb_data <= bus.vote_data_i;
      end
   end

   // Saturating statistics counters; clear beats a same-cycle increment.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_cnt_i) begin
         r_mis_cnt <= '0;
         r_cor_cnt <= '0;
      end else begin
         if (w_mis_inc && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + 1'b1;
         if (w_cor_inc && (r_cor_cnt != '1)) r_cor_cnt <= r_cor_cnt + 1'b1;
      end
   end

`ifdef TMR_SCRUB_ERR_LOG_EN
   logic              r_err_sticky;
   logic [ADDR_W-1:0] r_last_err_addr;

   // Error log: remember that a mismatch happened and where the latest one was.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_cnt_i) begin
         r_err_sticky    <= 1'b0;
         r_last_err_addr <= '0;
      end else if (w_mis_inc) begin
         r_err_sticky    <= 1'b1;
         r_last_err_addr <= r_ptr;
      end
   end

   assign err_sticky_o    = r_err_sticky;
   assign last_err_addr_o = r_last_err_addr;
`endif

   assign bus.rd_en_o    = (r_state == S_READ);
   assign bus.rd_addr_o  = r_ptr;
   assign bus.wb_req_o   = (r_state == S_WB);
   assign bus.wb_addr_o  = r_ptr;
   assign bus.wb_data_o  = r_wb_data;
   assign mismatch_cnt_o  = r_mis_cnt;
   assign corrected_cnt_o = r_cor_cnt;
   assign round_done_o   = (r_state == S_NEXT) && w_ptr_last;
   assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_tmr_scrub_controller.sv
// tb_tmr_scrub_controller: drives the scrubber as the bank/voter would and checks
// each address scrub against a transaction-level model (expected address, gap
// between reads, write-back length, saturating counters, error log).
module tb_tmr_scrub_controller;
   localparam int NUM_REGS = 4;
   localparam int N        = 16;
   localparam int PERIOD   = 2;
   localparam int CNT_W    = 2;
   localparam int AW       = $clog2(NUM_REGS);
   localparam int MAXC     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             enable;
   logic             clear_cnt;
   logic [CNT_W-1:0] mis_cnt;
   logic [CNT_W-1:0] cor_cnt;
   logic             round_done;
   logic             busy;
`ifdef TMR_SCRUB_ERR_LOG_EN
   logic             err_sticky;
   logic [AW-1:0]    last_err_addr;
`endif

   tmr_scrub_if #(.ADDR_W(AW), .N(N)) bus ();

   tmr_scrub_controller #(
      .NUM_REGS(NUM_REGS), .N(N), .PERIOD(PERIOD), .CNT_W(CNT_W)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .enable_i       (enable),
      .clear_cnt_i    (clear_cnt),
      .bus            (bus),
      .mismatch_cnt_o (mis_cnt),
      .corrected_cnt_o(cor_cnt),
      .round_done_o   (round_done),
      .busy_o         (busy)
`ifdef TMR_SCRUB_ERR_LOG_EN
      ,
      .err_sticky_o   (err_sticky),
      .last_err_addr_o(last_err_addr)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   int m_ptr    = 0;
   int m_mis    = 0;
   int m_cor    = 0;
   int m_sticky = 0;
   int m_last   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v < MAXC) ? v + 1 : MAXC;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Noise on inputs that must have no effect in the current state.
   task automatic rand_bg();
      bus.user_wr_i       = 1'($urandom % 2);
      bus.user_addr_i     = AW'($urandom % NUM_REGS);
      bus.vote_mismatch_i = 1'($urandom % 2);
      bus.vote_data_i     = N'($urandom);
      bus.wb_gnt_i        = 1'($urandom % 2);
   endtask

   // Random user write to any address other than addr.
   task automatic other_write(input int addr);
      bus.user_wr_i   = 1'($urandom % 2);
      bus.user_addr_i = AW'((addr + 1 + int'($urandom % (NUM_REGS - 1))) % NUM_REGS);
   endtask

   task automatic chk_errlog(input string tag);
`ifdef TMR_SCRUB_ERR_LOG_EN
      chk({tag, "_sticky"}, 32'(err_sticky), m_sticky);
      chk({tag, "_last"}, 32'(last_err_addr), m_last);
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   // Wait for the next read strobe; it must come PERIOD+1 cycles after the
   // cycle in which the controller left NEXT or saw enable in IDLE.
   task automatic wait_rd();
      int  k;
      bit  seen;
      seen = 1'b0;
      for (k = 1; k <= 60; k++) begin
         rand_bg();
         step();
         if (bus.rd_en_o) begin
            seen = 1'b1;
            break;
         end
         chk("quiet_strobes", 32'({bus.wb_req_o, round_done}), 0);
      end
      chk("rd_seen", 32'(seen), 1);
      if (seen) begin
         chk("rd_gap", k, PERIOD + 1);
         chk("rd_addr", 32'(bus.rd_addr_o), m_ptr);
      end
   endtask

   // One address scrub. w = WB cycles until grant, hit = cycle of a same-address
   // user write (0 none, -1 during capture, 1..w during write-back).
   task automatic scrub(input bit mis, input logic [N-1:0] data, input int w,
                        input int hit, input bit clr, input bit drop_en, input bit do_rst);
      bit go_wb;
      int addr;
      int wb_cycles;
      wait_rd();
      addr      = m_ptr;
      wb_cycles = 0;
      step();
      chk("cap_busy", 32'(busy), 1);
      chk("cap_rd_en", 32'(bus.rd_en_o), 0);
      go_wb = mis && (hit != -1);
      bus.vote_data_i     = data;
      bus.vote_mismatch_i = mis;
      bus.wb_gnt_i        = 1'($urandom % 2);
      clear_cnt           = clr;
      if (hit == -1) begin
         bus.user_wr_i   = 1'b1;
         bus.user_addr_i = AW'(addr);
      end else begin
         other_write(addr);
      end
      if (drop_en && !go_wb) enable = 1'b0;
      if (clr) begin
         m_mis = 0; m_cor = 0; m_sticky = 0; m_last = 0;
      end else if (mis) begin
         m_mis = sat(m_mis); m_sticky = 1; m_last = addr;
      end
      step();
      clear_cnt = 1'b0;
      if (go_wb) begin
         for (int i = 1; i <= w; i++) begin
            wb_cycles++;
            chk("wb_req", 32'(bus.wb_req_o), 1);
            chk("wb_addr", 32'(bus.wb_addr_o), addr);
            chk("wb_data", 32'(bus.wb_data_o), 32'(data));
            chk("mis_cnt_wb", 32'(mis_cnt), m_mis);
            bus.vote_data_i     = N'($urandom);
            bus.vote_mismatch_i = 1'($urandom % 2);
            bus.wb_gnt_i        = (i == w);
            if (i == hit) begin
               bus.user_wr_i   = 1'b1;
               bus.user_addr_i = AW'(addr);
            end else begin
               other_write(addr);
            end
            if (drop_en && i == 1) enable = 1'b0;
            if (do_rst && i == 2) begin
               rst_n = 1'b0;
               step();
               rst_n = 1'b1;
               bus.wb_gnt_i = 1'b0;
               m_ptr = 0; m_mis = 0; m_cor = 0; m_sticky = 0; m_last = 0;
               chk("rst_wb_req", 32'(bus.wb_req_o), 0);
               chk("rst_busy", 32'(busy), 0);
               chk("rst_rd_en", 32'(bus.rd_en_o), 0);
               chk("rst_mis_cnt", 32'(mis_cnt), 0);
               chk("rst_cor_cnt", 32'(cor_cnt), 0);
               chk("rst_wb_data", 32'(bus.wb_data_o), 0);
               chk("rst_ptr", 32'(bus.rd_addr_o), 0);
               chk_errlog("rst");
               $display("scrub addr=%0d mis=%0d reset during write-back", addr, mis);
               return;
            end
            if (i == w) m_cor = sat(m_cor);
            step();
            if (i == hit) break;
         end
         bus.wb_gnt_i = 1'b0;
      end
      other_write(addr);
      chk("next_wb_req", 32'(bus.wb_req_o), 0);
      chk("next_busy", 32'(busy), 1);
      chk("round_done", 32'(round_done), 32'(addr == NUM_REGS - 1));
      chk("mis_cnt", 32'(mis_cnt), m_mis);
      chk("cor_cnt", 32'(cor_cnt), m_cor);
      chk_errlog("next");
      m_ptr = (addr + 1) % NUM_REGS;
      $display("scrub addr=%0d mis=%0d wb_cycles=%0d hit=%0d clr=%0d drop=%0d mis_cnt=%0d cor_cnt=%0d",
               addr, mis, wb_cycles, hit, clr, drop_en, mis_cnt, cor_cnt);
      if (drop_en) begin
         step();
         chk("drop_idle", 32'(busy), 0);
         repeat (1 + int'($urandom % 3)) begin
            rand_bg();
            step();
            chk("drop_idle_busy", 32'(busy), 0);
            chk("drop_idle_rd", 32'(bus.rd_en_o), 0);
         end
         enable = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r, w, hit;
      rst_n = 1'b0; enable = 1'b0; clear_cnt = 1'b0;
      bus.user_wr_i = 1'b0; bus.user_addr_i = '0; bus.vote_mismatch_i = 1'b0;
      bus.vote_data_i = '0; bus.wb_gnt_i = 1'b0;
      repeat (3) step();
      chk("reset_rd_en", 32'(bus.rd_en_o), 0);
      chk("reset_wb_req", 32'(bus.wb_req_o), 0);
      chk("reset_round", 32'(round_done), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_mis", 32'(mis_cnt), 0);
      chk("reset_cor", 32'(cor_cnt), 0);
      chk("reset_wb_data", 32'(bus.wb_data_o), 0);
      chk_errlog("reset");
      rst_n = 1'b1;
      repeat (3) begin
         rand_bg();
         step();
         chk("idle_hold", 32'({busy, bus.rd_en_o}), 0);
      end
      enable = 1'b1;

      // Clean walk: 0,1,2,3,0 then 1.
      repeat (6) scrub(1'b0, N'($urandom), 1, 0, 1'b0, 1'b0, 1'b0);
      // Mismatch at addr 2, grant on the third request cycle.
      scrub(1'b1, 16'hA5A5, 3, 0, 1'b0, 1'b0, 1'b0);
      // Clear counters on a clean address 3, then addr 0,1 clean.
      scrub(1'b0, N'($urandom), 1, 0, 1'b1, 1'b0, 1'b0);
      repeat (2) scrub(1'b0, N'($urandom), 1, 0, 1'b0, 1'b0, 1'b0);
      // Mismatch at addr 2, user write to addr 2 in the second WB cycle.
      scrub(1'b1, 16'hA5A5, 3, 2, 1'b0, 1'b0, 1'b0);
      // Saturation: five mismatches, first one superseded at capture.
      for (int i = 0; i < 5; i++)
         scrub(1'b1, N'($urandom), 1 + int'($urandom % 3), (i == 0) ? -1 : 0, 1'b0, 1'b0, 1'b0);
      // Sixth mismatch together with clear.
      scrub(1'b1, N'($urandom), 2, 0, 1'b1, 1'b0, 1'b0);
      // Grant and same-address user write in the same cycle.
      scrub(1'b1, N'($urandom), 2, 2, 1'b0, 1'b0, 1'b0);
      // Enable dropped during write-back, then during a clean scrub.
      scrub(1'b1, N'($urandom), 3, 0, 1'b0, 1'b1, 1'b0);
      scrub(1'b0, N'($urandom), 1, 0, 1'b0, 1'b1, 1'b0);
      // Reset during write-back.
      scrub(1'b1, N'($urandom), 3, 0, 1'b0, 1'b0, 1'b1);

      // Randomized scrubs.
      for (int i = 0; i < 40; i++) begin
         w = 1 + int'($urandom % 4);
         r = int'($urandom % 4);
         hit = (r == 0) ? 0 : (r == 1) ? -1 : (r == 2) ? 1 + int'($urandom % w) : 0;
         scrub(1'($urandom % 2), N'($urandom), w, hit,
               ($urandom % 8) == 0, ($urandom % 6) == 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
